multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are even and >= 8.
REQ-002 SHALL have port Clock, input, 1 bit; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port Start, input, 1 bit; request to accept an operation.
REQ-005 SHALL have ports A and B, input, WIDTH bits each; operands.
REQ-006 SHALL have port FunSel, input, 4 bits; operation select.
REQ-007 SHALL have port WF, input, 1 bit; flag write enable.
REQ-008 SHALL have port Busy, output, 1 bit; high while an operation is in flight.
REQ-009 SHALL have port Done, output, 1 bit; one-cycle completion pulse.
REQ-010 SHALL have port ALUOut, output, WIDTH bits, registered; result.
REQ-011 SHALL have port FlagsOut, output, 4 bits, registered; {Z,C,N,O}.

Function
REQ-012 SHALL decode FunSel as follows:
- 0 ADD; 1 ADC (+C from FlagsOut); 2 SUB (A-B)
- 3 AND; 4 OR; 5 XOR
- 6 LSL by 1; 7 LSR by 1; 8 ASR by 1
- 9 MUL, low WIDTH bits of the unsigned product
- 10 MULH, high WIDTH bits of the unsigned product
- 11 DIVU, quotient; 12 REMU, remainder
- 13-15 pass A
REQ-013 SHALL capture A, B, FunSel, WF and the current C flag when Start=1 in the IDLE state; later changes to these inputs SHALL have no effect on the operation.
REQ-014 SHALL implement FSM states IDLE, ITER and DONE:
- IDLE, Start, FunSel 9-12 -> ITER.
- IDLE, Start, any other FunSel -> DONE.
- ITER -> DONE after exactly WIDTH iterations.
- DONE -> IDLE unconditionally.
REQ-015 SHALL implement MUL/MULH as shift-add and DIVU/REMU as restoring division, one bit per cycle, using no combinational multiplier or divider.
REQ-016 SHALL assert Busy in ITER and DONE; Start SHALL be ignored while Busy=1.
REQ-017 SHALL assert Done only in DONE, with ALUOut and FlagsOut valid in that same cycle; latency from the Start cycle t SHALL be Done at t+1 for single-cycle ops and t+WIDTH+1 for FunSel 9-12.
REQ-018 SHALL allow back-to-back operations: a Start in the first IDLE cycle after DONE is accepted.
REQ-019 SHALL update ALUOut on every completed operation and hold it otherwise.
REQ-020 SHALL update FlagsOut at completion only if the captured WF=1, and hold it otherwise.
REQ-021 SHALL compute flags at completion:
- Z = (result == 0); N = result[WIDTH-1].
- ADD/ADC: C = carry out; O = signed overflow.
- SUB: C = (B > A) unsigned; O = signed overflow.
- LSL: C = A[WIDTH-1]; LSR/ASR: C = A[0].
- MUL: C = (high half != 0).
- DIVU/REMU: O = (B == 0).
- All other cases: C and O retain their previous values.
REQ-022 SHALL, when DIVU/REMU has B=0, produce quotient all-ones and remainder A, with the same latency as a normal divide.

Reset
REQ-023 SHALL, on Reset=1 at a clock edge, set ALUOut=0, FlagsOut=0, Busy=0, Done=0 and the state to IDLE.
REQ-024 SHALL give Reset priority over Start; a Reset mid-ITER aborts the operation with no Done pulse and no output update.

Verification
REQ-025 WIDTH=32, ADD, A=0xFFFFFFFF, B=1, WF=1 -> Done at t+1, ALUOut=0, FlagsOut=4'b1100.
REQ-026 MUL, A=B=0x00010000, WF=1 -> Done at t+33, ALUOut=0, Z=1, C=1; then MULH with the same operands -> ALUOut=1.
REQ-027 DIVU, A=100, B=7 -> ALUOut=14 at t+33; REMU -> ALUOut=2; DIVU, A=5, B=0 -> ALUOut=0xFFFFFFFF, N=1, O=1.
REQ-028 SUB, A=3, B=5, WF=0 -> ALUOut=0xFFFFFFFE, FlagsOut unchanged; then ADC, A=B=0 with C=1 -> ALUOut=1.
REQ-029 Start pulsed during ITER -> ignored, one Done only; Reset at iteration 10 -> next cycle Busy=0, no Done, ALUOut=0.
REQ-030 Rerun REQ-025 to REQ-027 with WIDTH=16 -> MUL/DIV latency 17, results scaled to 16 bits.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle add/logic/shift ops, bit-serial shift-add multiply
// and restoring divide sharing one {hi,lo} working register pair.
//
// state | meaning
// IDLE  | waiting for Start; single-cycle ops complete on the accepting edge
// ITER  | one multiply/divide bit per cycle, WIDTH cycles total
// DONE  | Done pulse; ALUOut/FlagsOut hold the finished result
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FunSel,
  input  logic             WF,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [3:0]       fun_q;
  logic             wf_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi, lo;

  logic             is_multi_in, is_div_in, is_div_q;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_o;
  logic [WIDTH:0]   add_ext;

  logic [WIDTH:0]   sum_ext, shifted, diff;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] mc_res;
  logic             mc_c, mc_o;

  assign is_multi_in = (FunSel >= 4'd9) && (FunSel <= 4'd12);
  assign is_div_in   = (FunSel == 4'd11) || (FunSel == 4'd12);
  assign is_div_q    = (fun_q == 4'd11) || (fun_q == 4'd12);

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = is_multi_in ? ITER : DONE;
      ITER: begin
        Busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops evaluate straight from the inputs on the accepting edge.
  always_comb begin
    sc_res  = A;
    sc_c    = FlagsOut[2];
    sc_o    = FlagsOut[0];
    add_ext = '0;
    case (FunSel)
      4'd0: begin
        add_ext = {1'b0, A} + {1'b0, B};
        sc_res  = add_ext[MSB:0];
        sc_c    = add_ext[WIDTH];
        sc_o    = (A[MSB] == B[MSB]) && (sc_res[MSB] != A[MSB]);
      end
      4'd1: begin
        add_ext = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, FlagsOut[2]};
        sc_res  = add_ext[MSB:0];
        sc_c    = add_ext[WIDTH];
        sc_o    = (A[MSB] == B[MSB]) && (sc_res[MSB] != A[MSB]);
      end
      4'd2: begin
        sc_res = A - B;
        sc_c   = (B > A);
        sc_o   = (A[MSB] != B[MSB]) && (sc_res[MSB] != A[MSB]);
      end
      4'd3: sc_res = A & B;
      4'd4: sc_res = A | B;
      4'd5: sc_res = A ^ B;
      4'd6: begin
        sc_res = {A[MSB-1:0], 1'b0};
        sc_c   = A[MSB];
      end
      4'd7: begin
        sc_res = {1'b0, A[MSB:1]};
        sc_c   = A[0];
      end
      4'd8: begin
        sc_res = {A[MSB], A[MSB:1]};
        sc_c   = A[0];
      end
      default: sc_res = A;
    endcase
  end

  // One iteration step: hi/lo are product halves for multiply,
  // partial remainder/quotient for divide. B=0 naturally yields all-ones and A.
  always_comb begin
    sum_ext = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
    shifted = {hi, lo[MSB]};
    diff    = shifted - {1'b0, b_q};
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        hi_nxt = diff[MSB:0];
        lo_nxt = {lo[MSB-1:0], 1'b1};
      end else begin
        hi_nxt = shifted[MSB:0];
        lo_nxt = {lo[MSB-1:0], 1'b0};
      end
    end else begin
      hi_nxt = sum_ext[WIDTH:1];
      lo_nxt = {sum_ext[0], lo[MSB:1]};
    end
  end

  always_comb begin
    mc_c   = FlagsOut[2];
    mc_o   = FlagsOut[0];
    mc_res = hi_nxt;
    case (fun_q)
      4'd9: begin
        mc_res = lo_nxt;
        mc_c   = |hi_nxt;
      end
      4'd10: mc_res = hi_nxt;
      4'd11: begin
        mc_res = lo_nxt;
        mc_o   = ~|b_q;
      end
      default: begin
        mc_res = hi_nxt;
        mc_o   = ~|b_q;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      fun_q    <= '0;
      wf_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi       <= '0;
      lo       <= '0;
      ALUOut   <= '0;
      FlagsOut <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (Start) begin
            a_q   <= A;
            b_q   <= B;
            fun_q <= FunSel;
            wf_q  <= WF;
            if (is_multi_in) begin
              cnt <= CNT_LOAD;
              hi  <= '0;
              lo  <= is_div_in ? A : B;
            end else begin
              ALUOut <= sc_res;
              if (WF) FlagsOut <= {(sc_res == '0), sc_c, sc_res[MSB], sc_o};
            end
          end
        end
        ITER: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            ALUOut <= mc_res;
            if (wf_q) FlagsOut <= {(mc_res == '0), mc_c, mc_res[MSB], mc_o};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=32 and WIDTH=16: vector tables
// with hand-computed results/flags/latency, plus Start-while-busy and reset-abort sequences.
module tb_multicycle_alu;

  typedef struct {
    logic [3:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic        wf;
    logic [31:0] exp_out;
    logic [3:0]  exp_flags;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start32, start16;
  logic [31:0] a, b;
  logic [3:0]  fun;
  logic        wf;
  logic        busy32, done32, busy16, done16;
  logic [31:0] out32;
  logic [15:0] out16;
  logic [3:0]  fl32, fl16;

  int compared   = 0;
  int mismatched = 0;

  vec_t v32[22];
  vec_t v16[7];

  multicycle_alu #(.WIDTH(32)) dut32 (
    .Clock(clk), .Reset(rst), .Start(start32), .A(a), .B(b), .FunSel(fun), .WF(wf),
    .Busy(busy32), .Done(done32), .ALUOut(out32), .FlagsOut(fl32)
  );

  multicycle_alu #(.WIDTH(16)) dut16 (
    .Clock(clk), .Reset(rst), .Start(start16), .A(a[15:0]), .B(b[15:0]), .FunSel(fun), .WF(wf),
    .Busy(busy16), .Done(done16), .ALUOut(out16), .FlagsOut(fl16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input bit sel16, input int idx, input vec_t v);
    int n;
    bit seen;
    string tag;
    tag = sel16 ? "w16" : "w32";
    @(negedge clk);
    a = v.a; b = v.b; fun = v.fun; wf = v.wf;
    start32 = !sel16; start16 = sel16;
    n = 0; seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      start32 = 1'b0; start16 = 1'b0;
      a = ~v.a; b = v.b ^ 32'h5A5A_5A5A; fun = 4'd2; wf = ~v.wf;
      seen = sel16 ? done16 : done32;
    end
    check($sformatf("%s[%0d] latency", tag, idx), 32'(n), 32'(v.lat));
    check($sformatf("%s[%0d] ALUOut", tag, idx), sel16 ? {16'h0, out16} : out32, v.exp_out);
    check($sformatf("%s[%0d] FlagsOut", tag, idx), {28'h0, sel16 ? fl16 : fl32}, {28'h0, v.exp_flags});
  endtask

  initial begin
    int dcount, first;
    logic [31:0] dout;
    logic [3:0]  dfl;

    //        fun    a              b              wf    out            flags    lat
    v32[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b1100, 1};
    v32[1]  = '{4'd9,  32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 4'b1100, 33};
    v32[2]  = '{4'd10, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 4'b0100, 33};
    v32[3]  = '{4'd11, 32'd100,       32'd7,         1'b1, 32'd14,        4'b0100, 33};
    v32[4]  = '{4'd12, 32'd100,       32'd7,         1'b1, 32'd2,         4'b0100, 33};
    v32[5]  = '{4'd11, 32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 4'b0111, 33};
    v32[6]  = '{4'd12, 32'd5,         32'd0,         1'b1, 32'd5,         4'b0101, 33};
    v32[7]  = '{4'd2,  32'd3,         32'd5,         1'b0, 32'hFFFF_FFFE, 4'b0101, 1};
    v32[8]  = '{4'd1,  32'd0,         32'd0,         1'b1, 32'd1,         4'b0000, 1};
    v32[9]  = '{4'd2,  32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 4'b0110, 1};
    v32[10] = '{4'd0,  32'h7FFF_FFFF, 32'd1,         1'b1, 32'h8000_0000, 4'b0011, 1};
    v32[11] = '{4'd6,  32'h8000_0001, 32'd0,         1'b1, 32'h0000_0002, 4'b0101, 1};
    v32[12] = '{4'd7,  32'h0000_0003, 32'd0,         1'b1, 32'h0000_0001, 4'b0101, 1};
    v32[13] = '{4'd8,  32'h8000_0000, 32'd0,         1'b1, 32'hC000_0000, 4'b0011, 1};
    v32[14] = '{4'd3,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'h0000_0000, 4'b1001, 1};
    v32[15] = '{4'd4,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'hFFFF_FFFF, 4'b0011, 1};
    v32[16] = '{4'd5,  32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'hF0F0_0F0F, 4'b0011, 1};
    v32[17] = '{4'd13, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 4'b0001, 1};
    v32[18] = '{4'd9,  32'hFFFF_FFFF, 32'd2,         1'b1, 32'hFFFF_FFFE, 4'b0111, 33};
    v32[19] = '{4'd10, 32'hFFFF_FFFF, 32'd2,         1'b1, 32'h0000_0001, 4'b0101, 33};
    v32[20] = '{4'd1,  32'hFFFF_FFFF, 32'd0,         1'b1, 32'h0000_0000, 4'b1100, 1};
    v32[21] = '{4'd15, 32'h0000_0000, 32'h1111_1111, 1'b1, 32'h0000_0000, 4'b1100, 1};

    v16[0]  = '{4'd0,  32'hFFFF, 32'h0001, 1'b1, 32'h0000, 4'b1100, 1};
    v16[1]  = '{4'd9,  32'h0100, 32'h0100, 1'b1, 32'h0000, 4'b1100, 17};
    v16[2]  = '{4'd10, 32'h0100, 32'h0100, 1'b1, 32'h0001, 4'b0100, 17};
    v16[3]  = '{4'd11, 32'd100,  32'd7,    1'b1, 32'd14,   4'b0100, 17};
    v16[4]  = '{4'd12, 32'd100,  32'd7,    1'b1, 32'd2,    4'b0100, 17};
    v16[5]  = '{4'd11, 32'd5,    32'd0,    1'b1, 32'hFFFF, 4'b0111, 17};
    v16[6]  = '{4'd2,  32'd3,    32'd5,    1'b0, 32'hFFFE, 4'b0111, 1};

    rst = 1'b1; start32 = 1'b0; start16 = 1'b0;
    a = '0; b = '0; fun = '0; wf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy32", {31'h0, busy32}, 32'h0);
    check("reset done32", {31'h0, done32}, 32'h0);
    check("reset out32", out32, 32'h0);
    check("reset flags32", {28'h0, fl32}, 32'h0);
    check("reset busy16", {31'h0, busy16}, 32'h0);
    check("reset out16", {16'h0, out16}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) run_vec(1'b0, i, v32[i]);

    // Start pulsed mid-multiply must be ignored: one Done, original result.
    @(negedge clk);
    a = 32'd3; b = 32'd5; fun = 4'd9; wf = 1'b1; start32 = 1'b1;
    dcount = 0; first = 0; dout = '0; dfl = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      start32 = (n == 3);
      a = 32'h0000_FFFF; b = 32'd1; fun = 4'd0;
      if (n == 2) check("busy in ITER", {31'h0, busy32}, 32'h1);
      if (done32) begin
        dcount++;
        if (dcount == 1) begin
          first = n; dout = out32; dfl = fl32;
        end
      end
    end
    check("ignored start done count", 32'(dcount), 32'd1);
    check("ignored start latency", 32'(first), 32'd33);
    check("ignored start result", dout, 32'd15);
    check("ignored start flags", {28'h0, dfl}, 32'h0);
    check("result held", out32, 32'd15);
    check("idle busy low", {31'h0, busy32}, 32'h0);

    // Reset during divide iteration 10 aborts without Done.
    @(negedge clk);
    a = 32'd100; b = 32'd7; fun = 4'd11; wf = 1'b1; start32 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start32 = 1'b0;
    end
    check("busy before abort", {31'h0, busy32}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'h0, busy32}, 32'h0);
    check("abort done", {31'h0, done32}, 32'h0);
    check("abort out", out32, 32'h0);
    check("abort flags", {28'h0, fl32}, 32'h0);
    dcount = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done32) dcount++;
    end
    check("no done after abort", 32'(dcount), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(1'b1, i, v16[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
